palette_lut: RTL and testbench

Runtime-writable, multi-palette colour lookup for sprite rendering. Maps (palette select, 4-bit pixel index) to 24-bit RGB with a transparency flag. Sits between the sprite decoder and the VGA pixel mux. Replaces the fixed per-player colour tables with one RAM-backed block that self-loads defaults after reset and accepts live colour updates.

---
 rtl/palette_pkg.sv | 32 +++
 rtl/palette_flash_ctr.sv | 45 ++++
 rtl/palette_lut.sv | 179 +++++++++++++++++
 tb/tb_palette_lut.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared types, reset-time colour tables and helpers for palette_lut.
//   color_t       : RGB888 colour word
//   fsm_e         : INIT (self-load defaults) / RUN (lookups + writes)
//   DEFAULT_PAL   : four 16-entry default palettes
//   default_color : default for (pal, idx); palettes >= 4 reuse palette 0
package palette_pkg;

    localparam int COLOR_W_DEF = 24;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    typedef enum logic {INIT, RUN} fsm_e;

    localparam color_t DEFAULT_PAL [0:3][0:15] = '{
        '{24'h000000, 24'hffffff, 24'hb79bdc, 24'h8b5fbf, 24'h5e3a8c, 24'h2d1b4e, 24'hff6b6b, 24'hffd93d,
          24'h6bcb77, 24'h4d96ff, 24'hc0c0c0, 24'h808080, 24'h404040, 24'hff9f1c, 24'h2ec4b6, 24'h000000},
        '{24'h000000, 24'hffffff, 24'he63946, 24'ha8dadc, 24'h457b9d, 24'h1d3557, 24'hf1faee, 24'hffb703,
          24'hfb8500, 24'h023047, 24'h8ecae6, 24'h219ebc, 24'h606c38, 24'h283618, 24'hdda15e, 24'h000000},
        '{24'h000000, 24'hffffff, 24'h2a9d8f, 24'he9c46a, 24'hf4a261, 24'he76f51, 24'h264653, 24'h90be6d,
          24'h43aa8b, 24'h577590, 24'hf94144, 24'hf3722c, 24'hf8961e, 24'hf9c74f, 24'h4d908e, 24'h000000},
        '{24'h000000, 24'hffffff, 24'h7209b7, 24'h3a0ca3, 24'h4361ee, 24'h4cc9f0, 24'hf72585, 24'hb5179e,
          24'h560bad, 24'h480ca8, 24'h3f37c9, 24'h4895ef, 24'h06d6a0, 24'hffd166, 24'hef476f, 24'h000000}
    };

    // Palettes 4..7 have no dedicated table and fall back to palette 0.
    function automatic color_t default_color(input logic [2:0] pal, input logic [3:0] idx);
        logic [1:0] p;
        p = pal[2] ? 2'd0 : pal[1:0];
        return DEFAULT_PAL[p][idx];
    endfunction

endpackage

// File: rtl/palette_flash_ctr.sv
// palette_flash_ctr: per-palette hit-flash frame countdown.
// Built only when PALETTE_FLASH_EN is defined.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_load        : trigger (already qualified by RUN); loads FLASH_FRAMES
//   i_dec         : frame-start pulse; decrements a nonzero count
//   o_active      : count is nonzero
`ifdef PALETTE_FLASH_EN
module palette_flash_ctr
    import palette_pkg::*;
#(
    parameter  int FLASH_FRAMES = 8,
    localparam int CNT_W        = $clog2(FLASH_FRAMES + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_active
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A trigger landing on a frame boundary restarts the flash rather than
    // losing a frame, so load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = CNT_W'(FLASH_FRAMES);
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_active = (cnt_q != '0);

endmodule
`endif

// File: rtl/palette_lut.sv
// palette_lut: runtime-writable multi-palette colour lookup for sprites.
// After reset the INIT state writes one default entry per cycle
// (NUM_PAL*2^IDX_W cycles), then RUN accepts lookups and writes.
// Lookups have 2-cycle latency, fully pipelined.
// Optional feature macro: PALETTE_FLASH_EN (per-palette hit-flash to white).
// Ports:
//   i_clk, i_rst                         : clock, synchronous active-high reset
//   i_valid, i_pal_sel, i_idx            : lookup request
//   o_valid, o_color, o_transparent      : lookup result (idx 0 or bad palette -> transparent, colour 0)
//   i_wr_en, i_wr_pal, i_wr_idx, i_wr_data : live palette entry write (RUN only)
//   o_ready                              : defaults loaded; in RUN
//   i_frame_start, i_flash_trig          : flash timing/triggers (unused unless PALETTE_FLASH_EN)
module palette_lut
    import palette_pkg::*;
#(
    parameter  int NUM_PAL      = 4,
    parameter  int IDX_W        = 4,
    parameter  int COLOR_W      = 24,
    parameter  int FLASH_FRAMES = 8,
    localparam int PAL_W        = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [PAL_W-1:0]   i_pal_sel,
    input  logic [IDX_W-1:0]   i_idx,
    output logic               o_valid,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_transparent,
    input  logic               i_wr_en,
    input  logic [PAL_W-1:0]   i_wr_pal,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [COLOR_W-1:0] i_wr_data,
    output logic               o_ready,
    input  logic               i_frame_start,
    input  logic [NUM_PAL-1:0] i_flash_trig
);

    localparam int ADDR_W  = PAL_W + IDX_W;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRIES = NUM_PAL << IDX_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);
    localparam logic [PAL_W:0]    NUM_PAL_C = (PAL_W + 1)'(NUM_PAL);

    // ---------------- init / run FSM ----------------
    fsm_e              state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              run;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign run     = (state_q == RUN);
    assign o_ready = run;

    // ---------------- palette RAM ----------------
    // Address is {palette, index}, so the linear init counter walks every
    // entry of every palette in order.
    logic [COLOR_W-1:0] mem_q [0:DEPTH-1];

    logic [PAL_W-1:0]   init_pal;
    logic [IDX_W-1:0]   init_idx;
    logic [COLOR_W-1:0] init_data;
    logic               init_we, wr_ok;

    assign init_pal  = init_cnt_q[ADDR_W-1:IDX_W];
    assign init_idx  = init_cnt_q[IDX_W-1:0];
    assign init_data = COLOR_W'(default_color(3'(init_pal), 4'(init_idx)));
    assign init_we   = !i_rst && (state_q == INIT);
    assign wr_ok     = !i_rst && run && i_wr_en && ({1'b0, i_wr_pal} < NUM_PAL_C);

    always_ff @(posedge i_clk) begin
        if (init_we) begin
            mem_q[init_cnt_q] <= init_data;
        end else if (wr_ok) begin
            mem_q[{i_wr_pal, i_wr_idx}] <= i_wr_data;
        end
    end

    // ---------------- flash ----------------
    logic in_pal_ok;
    logic flash_hit;

    assign in_pal_ok = ({1'b0, i_pal_sel} < NUM_PAL_C);

`ifdef PALETTE_FLASH_EN
    logic [NUM_PAL-1:0] flash_act;

    for (genvar p = 0; p < NUM_PAL; p++) begin : g_flash
        palette_flash_ctr #(
            .FLASH_FRAMES(FLASH_FRAMES)
        ) u_ctr (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (run && i_flash_trig[p]),
            .i_dec   (i_frame_start),
            .o_active(flash_act[p])
        );
    end

    assign flash_hit = in_pal_ok && flash_act[i_pal_sel];
`else
    logic unused_flash;
    assign flash_hit    = 1'b0;
    assign unused_flash = ^{i_flash_trig, i_frame_start, FLASH_FRAMES[0]};
`endif

    // ---------------- lookup pipeline ----------------
    // vld_pipe_q[0]: stage-1 request valid, vld_pipe_q[1]: o_valid.
    logic [1:0]         vld_pipe_q;
    logic [PAL_W-1:0]   s1_pal_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic               s1_flash_q;
    logic [COLOR_W-1:0] color_q;
    logic               transp_q;

    logic               s1_pal_ok;
    logic               s2_transp;
    logic [COLOR_W-1:0] rd_color, s2_color;

    // Stage-2 reads the RAM before any same-edge write lands, so a write
    // on the stage-2 edge is seen only by later lookups.
    assign rd_color  = mem_q[{s1_pal_q, s1_idx_q}];
    assign s1_pal_ok = ({1'b0, s1_pal_q} < NUM_PAL_C);
    assign s2_transp = !s1_pal_ok || (s1_idx_q == '0);
    assign s2_color  = s2_transp  ? '0 :
                       s1_flash_q ? '1 : rd_color;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe_q <= '0;
            s1_pal_q   <= '0;
            s1_idx_q   <= '0;
            s1_flash_q <= 1'b0;
            color_q    <= '0;
            transp_q   <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], i_valid && run};
            s1_pal_q   <= i_pal_sel;
            s1_idx_q   <= i_idx;
            s1_flash_q <= flash_hit;
            // Result registers hold the last result between valid beats.
            if (vld_pipe_q[0]) begin
                color_q  <= s2_color;
                transp_q <= s2_transp;
            end
        end
    end

    assign o_valid       = vld_pipe_q[1];
    assign o_color       = color_q;
    assign o_transparent = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
module tb_palette_lut;

    localparam int NUM_PAL      = 4;
    localparam int IDX_W        = 4;
    localparam int COLOR_W      = 24;
    localparam int FLASH_FRAMES = 8;
    localparam int PAL_W        = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic [PAL_W-1:0]   i_pal_sel;
    logic [IDX_W-1:0]   i_idx;
    logic               o_valid;
    logic [COLOR_W-1:0] o_color;
    logic               o_transparent;
    logic               i_wr_en;
    logic [PAL_W-1:0]   i_wr_pal;
    logic [IDX_W-1:0]   i_wr_idx;
    logic [COLOR_W-1:0] i_wr_data;
    logic               o_ready;
    logic               i_frame_start;
    logic [NUM_PAL-1:0] i_flash_trig;

    always #5 clk = ~clk;

    palette_lut #(
        .NUM_PAL(NUM_PAL), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid(i_valid), .i_pal_sel(i_pal_sel), .i_idx(i_idx),
        .o_valid(o_valid), .o_color(o_color), .o_transparent(o_transparent),
        .i_wr_en(i_wr_en), .i_wr_pal(i_wr_pal), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .o_ready(o_ready), .i_frame_start(i_frame_start), .i_flash_trig(i_flash_trig)
    );

    // Independent copy of the reset-time palettes.
    localparam logic [23:0] DEF [4][16] = '{
        '{24'h000000, 24'hffffff, 24'hb79bdc, 24'h8b5fbf, 24'h5e3a8c, 24'h2d1b4e, 24'hff6b6b, 24'hffd93d,
          24'h6bcb77, 24'h4d96ff, 24'hc0c0c0, 24'h808080, 24'h404040, 24'hff9f1c, 24'h2ec4b6, 24'h000000},
        '{24'h000000, 24'hffffff, 24'he63946, 24'ha8dadc, 24'h457b9d, 24'h1d3557, 24'hf1faee, 24'hffb703,
          24'hfb8500, 24'h023047, 24'h8ecae6, 24'h219ebc, 24'h606c38, 24'h283618, 24'hdda15e, 24'h000000},
        '{24'h000000, 24'hffffff, 24'h2a9d8f, 24'he9c46a, 24'hf4a261, 24'he76f51, 24'h264653, 24'h90be6d,
          24'h43aa8b, 24'h577590, 24'hf94144, 24'hf3722c, 24'hf8961e, 24'hf9c74f, 24'h4d908e, 24'h000000},
        '{24'h000000, 24'hffffff, 24'h7209b7, 24'h3a0ca3, 24'h4361ee, 24'h4cc9f0, 24'hf72585, 24'hb5179e,
          24'h560bad, 24'h480ca8, 24'h3f37c9, 24'h4895ef, 24'h06d6a0, 24'hffd166, 24'hef476f, 24'h000000}
    };

    typedef struct packed {
        logic [23:0] color;
        logic        tr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [23:0] model [4][16];
    int          vectors     = 0;
    int          miscompares = 0;
    int          popped      = 0;

    // Scoreboard: every result beat is matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: o_valid=1 with nothing outstanding (color=%h)", o_color);
            end else begin
                mon_e = exp_q.pop_front();
                popped++;
                if (o_color !== mon_e.color || o_transparent !== mon_e.tr) begin
                    miscompares++;
                    $display("FAIL lookup: got color=%h tr=%b, want color=%h tr=%b",
                             o_color, o_transparent, mon_e.color, mon_e.tr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid       = 1'b0;
        i_wr_en       = 1'b0;
        i_frame_start = 1'b0;
        i_flash_trig  = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                model[p][i] = DEF[p][i];
    endtask

    function automatic exp_t expect_of(input int p, input int i);
        exp_t e;
        if (i == 0) begin
            e.color = 24'h0;
            e.tr    = 1'b1;
        end else begin
            e.color = model[p][i];
            e.tr    = 1'b0;
        end
        return e;
    endfunction

    // Drives one lookup for the next edge and records its expected result.
    task automatic lookup(input int p, input int i);
        i_valid   = 1'b1;
        i_pal_sel = p[1:0];
        i_idx     = i[3:0];
        exp_q.push_back(expect_of(p, i));
    endtask

    task automatic push_white();
        exp_t e;
        e.color = 24'hffffff;
        e.tr    = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int n;
        idle();
        i_pal_sel = '0; i_idx = '0; i_wr_pal = '0; i_wr_idx = '0; i_wr_data = '0;
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (o_valid !== 1'b0)        begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        vectors++; if (o_color !== 24'h0)       begin miscompares++; $display("FAIL reset_color: got %h want 000000", o_color); end
        vectors++; if (o_transparent !== 1'b0)  begin miscompares++; $display("FAIL reset_transp: got %b want 0", o_transparent); end
        vectors++; if (o_ready !== 1'b0)        begin miscompares++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        rst = 1'b0;
        model_reset();
        n = 0;
        while (o_ready !== 1'b1 && n < 200) begin tick(); n++; end
        vectors++; if (n != 64) begin miscompares++; $display("FAIL ready_latency: got %0d cycles want 64", n); end
    endtask

    task automatic test_basic_lookup();
        lookup(0, 1);
        tick();
        idle();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: o_valid=%b after 1 edge, want 0", o_valid); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_color !== 24'hffffff)
            begin miscompares++; $display("FAIL latency_2: valid=%b color=%h, want 1 ffffff", o_valid, o_color); end
        lookup(0, 2);
        tick();
        idle();
        tick();
        vectors++; if (o_color !== 24'hb79bdc) begin miscompares++; $display("FAIL pal0_idx2: got %h want b79bdc", o_color); end
        tick();
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = popped;
        for (int i = 0; i < 16; i++) begin lookup(0, i); tick(); end
        idle();
        tick();
        tick();
        vectors++; if (popped - p0 != 16) begin miscompares++; $display("FAIL b2b_count: got %0d results want 16", popped - p0); end
        for (int k = 0; k < 12; k++) begin
            lookup(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_write_collision();
        exp_t e;
        // First lookup reaches stage 2 on the write edge: old value.
        lookup(1, 5);
        tick();
        i_valid   = 1'b1;
        i_pal_sel = 2'd1;
        i_idx     = 4'd5;
        e.color   = 24'h123456;
        e.tr      = 1'b0;
        exp_q.push_back(e);
        i_wr_en   = 1'b1;
        i_wr_pal  = 2'd1;
        i_wr_idx  = 4'd5;
        i_wr_data = 24'h123456;
        tick();
        idle();
        model[1][5] = 24'h123456;
        tick();
        tick();
        // Two writes to the same entry on consecutive edges: the last wins.
        i_wr_en = 1'b1; i_wr_pal = 2'd2; i_wr_idx = 4'd7; i_wr_data = 24'haaaaaa;
        tick();
        i_wr_data = 24'hbbbbbb;
        tick();
        idle();
        model[2][7] = 24'hbbbbbb;
        lookup(2, 7); tick();
        lookup(2, 6); tick();
        lookup(1, 5); tick();
        idle();
        tick();
        tick();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL collision_drain: %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_init_ignored();
        int n, nv;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        i_valid = 1'b1; i_pal_sel = 2'd0; i_idx = 4'd2;
        i_wr_en = 1'b1; i_wr_pal = 2'd0; i_wr_idx = 4'd2; i_wr_data = 24'h111111;
        nv = 0;
        // Restart INIT part-way through.
        for (int k = 0; k < 20; k++) begin tick(); if (o_valid !== 1'b0) nv++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (o_ready !== 1'b1 && n < 200) begin tick(); n++; if (o_valid !== 1'b0) nv++; end
        idle();
        vectors++; if (nv != 0)  begin miscompares++; $display("FAIL init_valid: %0d valid beats during INIT want 0", nv); end
        vectors++; if (n != 64)  begin miscompares++; $display("FAIL init_restart: ready after %0d cycles want 64", n); end
        lookup(0, 2);
        tick();
        idle();
        tick();
        vectors++; if (o_color !== 24'hb79bdc) begin miscompares++; $display("FAIL init_write_ignored: got %h want b79bdc", o_color); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        i_wr_en = 1'b1; i_wr_pal = 2'd0; i_wr_idx = 4'd3; i_wr_data = 24'habcdef;
        tick();
        idle();
        model[0][3] = 24'habcdef;
        lookup(0, 3);
        tick();
        idle();
        tick();
        tick();
        // In-flight lookup (no expectation) killed by reset.
        i_valid = 1'b1; i_pal_sel = 2'd0; i_idx = 4'd3;
        tick();
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_flush: o_valid=%b want 0", o_valid); end
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: o_ready=%b want 0", o_ready); end
        rst = 1'b0;
        model_reset();
        n = 0;
        while (o_ready !== 1'b1 && n < 200) begin tick(); n++; end
        vectors++; if (n != 64) begin miscompares++; $display("FAIL midreset_init: ready after %0d cycles want 64", n); end
        lookup(0, 3);
        tick();
        idle();
        tick();
        vectors++; if (o_color !== 24'h8b5fbf) begin miscompares++; $display("FAIL midreset_default: got %h want 8b5fbf", o_color); end
        tick();
    endtask

`ifdef PALETTE_FLASH_EN
    task automatic test_flash();
        i_flash_trig = 4'b0100;
        tick();
        idle();
        for (int k = 0; k < FLASH_FRAMES; k++) begin
            i_valid = 1'b1; i_pal_sel = 2'd2; i_idx = 4'd4; push_white();
            tick();
            lookup(2, 0); tick();
            lookup(1, 4); tick();
            idle();
            i_frame_start = 1'b1;
            tick();
            i_frame_start = 1'b0;
        end
        lookup(2, 4); tick();
        lookup(2, 0); tick();
        idle();
        tick();
        tick();
        // Trigger and frame start together: the load wins.
        i_flash_trig  = 4'b0100;
        i_frame_start = 1'b1;
        tick();
        idle();
        i_valid = 1'b1; i_pal_sel = 2'd2; i_idx = 4'd4; push_white();
        tick();
        idle();
        for (int k = 0; k < FLASH_FRAMES - 1; k++) begin i_frame_start = 1'b1; tick(); i_frame_start = 1'b0; end
        i_valid = 1'b1; i_pal_sel = 2'd2; i_idx = 4'd4; push_white();
        tick();
        idle();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        lookup(2, 4); tick();
        idle();
        tick();
        tick();
    endtask
`else
    task automatic test_flash();
        i_flash_trig  = 4'b0100;
        i_frame_start = 1'b1;
        tick();
        idle();
        lookup(2, 4); tick();
        lookup(2, 0); tick();
        idle();
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_lookup();
        test_back_to_back();
        test_write_collision();
        test_init_ignored();
        test_reset_mid();
        test_flash();
        tick();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_drain: %0d outstanding want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
